// File: rtl/int_writeback.sv
// int_writeback: commits integer execute results into the register file,
// serves the decode read ports with write bypass, sequences execute traps
// and counts retired instructions.
module int_writeback #(
    parameter int XLEN      = 32,
    parameter int ALEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALEN-1:0]      decode_instruction_addr,
    input  logic [4:0]           decode_rd,
    input  logic                 input_valid,
    input  logic                 input_is_int,
    input  logic                 exec_int_output_valid,
    input  logic                 exec_int_exception,
    input  logic [XLEN-1:0]      exec_int_result,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 wb_stall,
    output logic                 wb_flush,
    output logic                 trap_valid,
    output logic [ALEN-1:0]      trap_addr,
    input  logic                 trap_ack,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // Entry 0 is held at zero and never written; it only exists so the read
    // mux can index with the raw 5-bit address.
    logic [XLEN-1:0] regs [0:31];

    logic            tag_valid;
    logic [4:0]      tag_rd;
    logic [ALEN-1:0] tag_addr;

    logic commit_fire;
    logic commit_ok;
    logic commit_trap;
    logic reg_write;

    // A result only commits in RUN and only when it matches a captured issue.
    always_comb begin
        commit_fire = (state == ST_RUN) && exec_int_output_valid && tag_valid;
        commit_ok   = commit_fire && !exec_int_exception;
        commit_trap = commit_fire && exec_int_exception;
        reg_write   = commit_ok && (tag_rd != 5'd0);
    end

    // Trap sequencer: exception -> one flush cycle -> halt until acknowledged.
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (commit_trap) next_state = ST_FLUSH;
            ST_FLUSH: next_state = ST_HALT;
            ST_HALT:  if (trap_ack) next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    // State register; the stall/flush/trap outputs are decodes of it.
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RUN;
        else      state <= next_state;
    end

    always_comb begin
        wb_stall   = (state != ST_RUN);
        wb_flush   = (state == ST_FLUSH);
        trap_valid = (state != ST_RUN);
    end

    // Capture rd/address of an accepted issue so the result can be matched a cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid <= 1'b0;
            tag_rd    <= 5'd0;
            tag_addr  <= '0;
        end else if (input_valid && input_is_int && !wb_stall) begin
            tag_valid <= 1'b1;
            tag_rd    <= decode_rd;
            tag_addr  <= decode_instruction_addr;
        end else begin
            tag_valid <= 1'b0;
        end
    end

    // Register file write; x0 is never touched after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_write) begin
            regs[tag_rd] <= exec_int_result;
        end
    end

    // Retired-instruction counter and faulting-address capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret   <= '0;
            trap_addr <= '0;
        end else begin
            if (commit_ok)   instret   <= instret + INSTRET_W'(1);
            if (commit_trap) trap_addr <= tag_addr;
        end
    end

    // Read ports with same-cycle bypass of the committing write.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs2_data = regs[rs2_addr];
        if (reg_write && (tag_rd == rs1_addr)) rs1_data = exec_int_result;
        if (reg_write && (tag_rd == rs2_addr)) rs2_data = exec_int_result;
        if (rs1_addr == 5'd0) rs1_data = '0;
        if (rs2_addr == 5'd0) rs2_data = '0;
    end

endmodule
